// File: rtl/mem_ctrl.sv
// Synchronous front-end for an asynchronous byte-wide SRAM: registered strobes, wait-state counter, owned data bus.
// Optional write readback/verify stage enabled by defining MEM_CTRL_RDBACK_EN.
module mem_ctrl #(
   parameter int ADDRLEN     = 8,
   parameter int WAIT_CYCLES = 6
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               req,
   input  logic               wr,
   input  logic [ADDRLEN-1:0] addr_in,
   input  logic [7:0]         wdata,
   output logic [7:0]         rdata,
   output logic               ready,
   output logic               busy,
   output logic               err,
   output logic               mem_oe_,
   output logic               mem_we_,
   output logic [ADDRLEN-1:0] mem_addr,
   inout  wire  [7:0]         mem_data,
   output logic [2:0]         o_dbg_state
);

   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WSU  = 3'd2,
      S_WR   = 3'd3,
      S_WHD  = 3'd4,
      S_DONE = 3'd5
`ifdef MEM_CTRL_RDBACK_EN
      , S_VFY = 3'd6
`endif
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [7:0]         r_wdata;
   logic               r_drive;
   logic [7:0]         r_rdata;
   logic               r_ready;
   logic               r_busy;
   logic               r_oe_n;
   logic               r_we_n;
   logic [ADDRLEN-1:0] r_addr;
   logic               w_cnt_zero;
`ifdef MEM_CTRL_RDBACK_EN
   logic               r_err;
`endif

   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_wdata <= '0;
         r_drive <= 1'b0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_addr  <= '0;
`ifdef MEM_CTRL_RDBACK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         // ready is a single-cycle pulse raised only on the edge entering DONE
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_addr  <= addr_in;
                  r_wdata <= wdata;
                  r_busy  <= 1'b1;
`ifdef MEM_CTRL_RDBACK_EN
                  r_err   <= 1'b0;
`endif
                  if (wr) begin
                     r_state <= S_WSU;
                     r_drive <= 1'b1;
                  end else begin
                     r_state <= S_RD;
                     r_oe_n  <= 1'b0;
                     r_cnt   <= CNT_LOAD;
                  end
               end
            end
            S_RD: begin
               if (w_cnt_zero) begin
                  r_rdata <= mem_data;
                  r_oe_n  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WSU: begin
               r_we_n  <= 1'b0;
               r_cnt   <= CNT_LOAD;
               r_state <= S_WR;
            end
            S_WR: begin
               if (w_cnt_zero) begin
                  r_we_n  <= 1'b1;
                  r_state <= S_WHD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WHD: begin
               // bus released on the same edge the verify read begins, so they never overlap
               r_drive <= 1'b0;
`ifdef MEM_CTRL_RDBACK_EN
               r_oe_n  <= 1'b0;
               r_cnt   <= CNT_LOAD;
               r_state <= S_VFY;
`else
               r_ready <= 1'b1;
               r_state <= S_DONE;
`endif
            end
`ifdef MEM_CTRL_RDBACK_EN
            S_VFY: begin
               if (w_cnt_zero) begin
                  r_err   <= (mem_data != r_wdata);
                  r_oe_n  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`endif
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_drive <= 1'b0;
            end
         endcase
      end
   end

   assign mem_data    = r_drive ? r_wdata : 8'hzz;
   assign rdata       = r_rdata;
   assign ready       = r_ready;
   assign busy        = r_busy;
   assign mem_oe_     = r_oe_n;
   assign mem_we_     = r_we_n;
   assign mem_addr    = r_addr;
   assign o_dbg_state = r_state;
`ifdef MEM_CTRL_RDBACK_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (!rst_)
      !(!mem_oe_ && !mem_we_));
   a_no_oe_with_drive: assert property (@(posedge clk) disable iff (!rst_)
      !(!mem_oe_ && r_drive));

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table, hand-written reset/handshake sequences, random ops against a memory model.
// Expectations follow MEM_CTRL_RDBACK_EN when it is defined for the build.
module tb_mem_ctrl;
   localparam int W      = 6;
   localparam int LAT_RD = W + 1;
`ifdef MEM_CTRL_RDBACK_EN
   localparam int LAT_WR = 2 * W + 3;
   localparam int WR_OE  = W;
`else
   localparam int LAT_WR = W + 3;
   localparam int WR_OE  = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic       req = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] addr_in = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       ready, busy, err, mem_oe_, mem_we_;
   logic [7:0] mem_addr;
   logic [2:0] dbg_state;
   wire  [7:0] mem_data;

   // ---------------- SRAM model ----------------
   logic [7:0] sram [256];
   bit         sram_wr_en = 1'b0;
   bit         preload = 1'b0;

   function automatic logic [7:0] pre_val(input logic [7:0] a);
      case (a)
         8'h03:   return 8'hF1;
         8'h05:   return 8'hF2;
         default: return a ^ 8'h5A;
      endcase
   endfunction

   assign mem_data = (mem_oe_ == 1'b0) ? sram[mem_addr] : 8'hzz;

   always @(posedge mem_we_ or posedge preload) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) sram[i] = pre_val(8'(i));
      end else if (sram_wr_en) begin
         sram[mem_addr] = mem_data;
      end
   end

   // ---------------- clock / DUT ----------------
   always #5 clk = ~clk;

   mem_ctrl #(.ADDRLEN(8), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_(rst_), .req(req), .wr(wr), .addr_in(addr_in), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy), .err(err),
      .mem_oe_(mem_oe_), .mem_we_(mem_we_), .mem_addr(mem_addr),
      .mem_data(mem_data), .o_dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] ref_mem [256];
   logic [7:0] last_rd;
   logic [7:0] exp_q [$];

   int         res_lat, res_oe, res_we, res_first_oe, res_first_we;
   int         res_bus_bad, res_overlap, res_hold_bad;
   logic [7:0] res_rdata;
   logic       res_err, res_err_c1, res_ready_after, res_busy_after;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Issue one request from IDLE and observe it cycle by cycle (cycle 1 follows the acceptance edge).
   task automatic run_op(input logic op_wr, input logic [7:0] a, input logic [7:0] d);
      int c;
      @(negedge clk);
      req = 1'b1; wr = op_wr; addr_in = a; wdata = d;
      @(posedge clk);
      res_lat = 0; res_oe = 0; res_we = 0; res_first_oe = 0; res_first_we = 0;
      res_bus_bad = 0; res_overlap = 0; res_hold_bad = 0; res_err_c1 = 1'b1;
      c = 0;
      while (res_lat == 0 && c < 40) begin
         @(negedge clk);
         c++;
         req = 1'b0;
         if (c == 1) res_err_c1 = err;
         if (!mem_oe_) begin
            res_oe++;
            if (res_first_oe == 0) res_first_oe = c;
         end
         if (!mem_we_) begin
            res_we++;
            if (res_first_we == 0) res_first_we = c;
         end
         if (!mem_oe_ && !mem_we_) res_overlap++;
         if (op_wr && c <= W + 2 && mem_data !== d) res_bus_bad++;
         if (mem_addr !== a || busy !== 1'b1) res_hold_bad++;
         if (ready) begin
            res_lat   = c;
            res_rdata = rdata;
            res_err   = err;
         end
      end
      @(negedge clk);
      res_ready_after = ready;
      res_busy_after  = busy;
   endtask

   task automatic check_op(input logic op_wr, input logic [7:0] exp_rd, input logic exp_err);
      chk("latency",        res_lat, op_wr ? LAT_WR : LAT_RD);
      chk("oe_low_cycles",  res_oe, op_wr ? WR_OE : W);
      chk("we_low_cycles",  res_we, op_wr ? W : 0);
      chk("first_strobe",   op_wr ? res_first_we : res_first_oe, op_wr ? 2 : 1);
      chk("bus_drive",      res_bus_bad, 0);
      chk("strobe_overlap", res_overlap, 0);
      chk("addr_busy_hold", res_hold_bad, 0);
      chk("rdata",          res_rdata, exp_rd);
      chk("err",            res_err, exp_err);
      chk("err_clear",      res_err_c1, 0);
      chk("ready_one_cyc",  res_ready_after, 0);
      chk("busy_after",     res_busy_after, 0);
   endtask

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int nready;
      int rcyc [3];
      int nr;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_ready", ready, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_err",   err, 0);
      chk("rst_oe",    mem_oe_, 1);
      chk("rst_we",    mem_we_, 1);
      chk("rst_addr",  mem_addr, 8'h00);
      rst_ = 1'b1;
      preload = 1'b1; #1 preload = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = pre_val(8'(i));
      last_rd = 8'h00;

      // reset asserted in the 3rd RD cycle
      @(negedge clk);
      req = 1'b1; wr = 1'b0; addr_in = 8'h03;
      @(posedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         req = 1'b0;
      end
      chk("pre_rst_oe_low", mem_oe_, 0);
      rst_ = 1'b0;
      #1;
      chk("mid_rst_oe", mem_oe_, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", mem_addr, 8'h00);
      chk("mid_rst_state", dbg_state, 0);
      nready = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 2) rst_ = 1'b1;
         if (ready) nready++;
      end
      chk("mid_rst_no_ready", nready, 0);
      chk("post_rst_rdata", rdata, 8'h00);
      chk("post_rst_oe", mem_oe_, 1);
      chk("post_rst_we", mem_we_, 1);
      chk("post_rst_busy", busy, 0);

      // vector table, SRAM writes enabled
      sram_wr_en = 1'b1;
      vecs[0] = '{1'b0, 8'h03, 8'h00, 8'hF1};
      vecs[1] = '{1'b1, 8'h20, 8'hA5, 8'hF1};
      vecs[2] = '{1'b0, 8'h20, 8'h00, 8'hA5};
      vecs[3] = '{1'b1, 8'hFF, 8'h3C, 8'hA5};
      vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
      vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h5A};
      vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h5A};
      vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         check_op(vecs[i].wr, vecs[i].exp_rdata, 1'b0);
         if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
         else last_rd = vecs[i].exp_rdata;
      end

      // requests during a read are ignored
      @(negedge clk);
      req = 1'b1; wr = 1'b0; addr_in = 8'h03;
      @(posedge clk);
      nready = 0; nr = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         req = (c == 2 || c == 5);
         wr = 1'b1; addr_in = 8'h20; wdata = 8'h11;
         if (ready) begin
            nready++;
            nr = c;
         end
      end
      req = 1'b0;
      chk("hs_one_ready", nready, 1);
      chk("hs_ready_cycle", nr, LAT_RD);
      chk("hs_rdata", rdata, 8'hF1);
      last_rd = 8'hF1;

      // req held high: back-to-back reads
      @(negedge clk);
      req = 1'b1; wr = 1'b0; addr_in = 8'h03;
      @(posedge clk);
      nr = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (ready && nr < 3) begin
            rcyc[nr] = c;
            nr++;
         end
      end
      req = 1'b0;
      chk("b2b_count", nr, 3);
      chk("b2b_first", rcyc[0], LAT_RD);
      chk("b2b_gap1", rcyc[1] - rcyc[0], LAT_RD + 1);
      chk("b2b_gap2", rcyc[2] - rcyc[1], LAT_RD + 1);
      for (int c = 0; c < 30; c++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("b2b_drain", busy, 0);

      // random ops against the memory model
      for (int n = 0; n < 30; n++) begin
         logic       w;
         logic [7:0] a, d;
         w = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 255));
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(w ? last_rd : ref_mem[a]);
         run_op(w, a, d);
         check_op(w, exp_q.pop_front(), 1'b0);
         if (w) ref_mem[a] = d;
         else last_rd = ref_mem[a];
      end

      // readback behaviour with SRAM writes disabled (address 0x05 holds 0xF2)
      sram_wr_en = 1'b0;
`ifdef MEM_CTRL_RDBACK_EN
      run_op(1'b1, 8'h05, 8'h55);
      check_op(1'b1, last_rd, 1'b1);
      repeat (3) @(negedge clk);
      chk("err_hold", err, 1);
      run_op(1'b1, 8'h05, 8'hF2);
      check_op(1'b1, last_rd, 1'b0);
`else
      run_op(1'b1, 8'h05, 8'h55);
      check_op(1'b1, last_rd, 1'b0);
      chk("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Synchronous front-end controller for the asynchronous byte-wide SRAM (`MEM`). It accepts single-byte read/write requests from the core on a `req`/`ready` handshake. It generates registered `oe_`/`we_` strobes and the address, and owns the bidirectional data bus. A programmable wait-state counter covers the SRAM access time.

## Interface
- `ADDRLEN`, 8: address width; matches the SRAM `addr` width.
- `WAIT_CYCLES`, 6: clock cycles a strobe is held low. Must be ≥1 and at least ceil(access time / clock period); 54 ns at 10 ns gives 6.
- `clk`  input  1  rising-edge clock.
- `rst_`  input  1  asynchronous, active-low reset.
- `req`  input  1  request; sampled only in IDLE.
- `wr`  input  1  1 = write, 0 = read; latched with `req`.
- `addr_in`  input  ADDRLEN  request address; latched with `req`.
- `wdata`  input  8  write data; latched with `req`.
- `rdata`  output  8  read data register; holds the last read value.
- `ready`  output  1  one-cycle completion pulse.
- `busy`  output  1  high in every state except IDLE.
- `err`  output  1  readback mismatch flag (see Configuration).
- `mem_oe_`  output  1  SRAM output enable, active low, registered.
- `mem_we_`  output  1  SRAM write enable, active low, registered.
- `mem_addr`  output  ADDRLEN  SRAM address, registered.
- `mem_data`  inout  8  SRAM data bus.

## Operation
- States:
  - IDLE
  - RD (read access)
  - WSU (write setup)
  - WR (write access)
  - WHD (write hold)
  - VFY (readback; only when the macro is defined)
  - DONE
- IDLE with `req`=1:
  - latch `wr`, `addr_in` and `wdata`.
  - `mem_addr` <= `addr_in`.
  - Next state is RD when `wr`=0, WSU when `wr`=1.
  - `err` clears on acceptance.
- RD: `mem_oe_`=0 for exactly WAIT_CYCLES cycles. On the edge ending the last RD cycle, `rdata` <= `mem_data`, then go to DONE.
- WSU: one cycle. `mem_data` is driven with the latched data and `mem_we_`=1. Go to WR.
- WR: `mem_we_`=0 for exactly WAIT_CYCLES cycles. Go to WHD.
- WHD: one cycle. `mem_we_`=1 and data is still driven. Go to VFY if the macro is defined, else DONE.
- DONE: `ready`=1 for one cycle, then go to IDLE.
- Wait counter:
  - width `$clog2(WAIT_CYCLES+1)`.
  - loads WAIT_CYCLES-1 on entry to RD, WR or VFY.
  - the state exits when the counter reads 0.
- Bus rule: `mem_data` is driven only in WSU, WR and WHD, and is Z in all other states. `mem_oe_`=0 and a driven bus never coincide. `mem_oe_` and `mem_we_` are never low together.
- `mem_addr` is stable from the acceptance edge until IDLE is re-entered.

## Timing
- Reset (`rst_`=0, asynchronous), applied immediately in any state, including mid-access:
  - state IDLE, counter 0.
  - `mem_oe_`=1, `mem_we_`=1, `mem_addr`=0.
  - `rdata`=0, `ready`=0, `busy`=0, `err`=0.
  - `mem_data`=Z.
  - An interrupted access never produces `ready`.
- Acceptance edge = edge 0.
- Read: `mem_oe_` is low during cycles 1..W (W = WAIT_CYCLES). `rdata` is valid and `ready`=1 in cycle W+1.
- Write: WSU in cycle 1, `mem_we_` low in cycles 2..W+1, WHD in W+2, `ready` in W+3.
- Write with readback: `ready` in 2W+3; `err` is valid in the same cycle.
- `req` outside IDLE is ignored; there is no queuing. `req` held high through DONE is accepted on the first IDLE cycle, so the minimum issue interval is latency+1.

## Configuration
- Macro: `MEM_CTRL_RDBACK_EN`.
- Defined: after WHD the controller enters VFY.
  - VFY drives `mem_oe_`=0 for WAIT_CYCLES cycles and samples `mem_data`.
  - `err` <= (sample != latched write data), then go to DONE.
  - `err` holds until the next accepted request or reset.
  - `rdata` is not updated by VFY.
- Undefined: there is no VFY state and `err` is tied to 0.

## Test plan
All scenarios use W=6 and a 10 ns clock against the 54 ns SRAM model.
- Reset: assert `rst_`=0 in the 3rd RD cycle. `mem_oe_` rises to 1 at that timestep, `busy`=0 and `ready` never pulses. After release, IDLE outputs match the reset values.
- Read: addr 0x03 (preloaded 0xF1). `mem_oe_` is low exactly 6 cycles, `rdata`=0xF1 and `ready` is high in cycle 7 only.
- Write then read, with SRAM writes enabled: write 0x20←0xA5, then read 0x20.
  - `mem_we_` is low exactly 6 cycles, with the bus driven one cycle before and one cycle after.
  - `ready` pulses in cycle 9; the read returns 0xA5.
- Handshake: pulse `req` in cycles 2 and 5 of a read; both pulses are ignored and only one `ready` appears. Holding `req`=1 continuously gives back-to-back reads spaced 8 cycles apart.
- Readback: build with `MEM_CTRL_RDBACK_EN` and with SRAM writes disabled. Write 0x05←0x55 (memory holds 0xF2): `ready` in cycle 15 with `err`=1.
  - Write 0x05←0xF2 gives `err`=0.
  - Without the macro, `ready` arrives in cycle 9 and `err` stays 0.
